// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one single-port line memory between the I-cache
// (read-only) and D-cache (read/write) refill paths, with a WAIT-state timeout.
module mem_line_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  output logic              i_resp_err,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_data_write,
  input  logic [LINE_W-1:0] mem_data_read,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(3));
  localparam logic [7:0]        TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q;
  logic                owner_q;   // 1 = D-side owns the current transaction
  logic                last_d_q;  // 1 = most recent grant went to D-side
  logic [7:0]          cnt_q;
  logic                mem_req_valid_q;
  logic                mem_req_rw_q;
  logic [ADDR_W-1:0]   mem_req_addr_q;
  logic [LINE_W-1:0]   mem_data_write_q;
  logic                i_resp_valid_q;
  logic [LINE_W-1:0]   i_resp_data_q;
  logic                i_resp_err_q;
  logic                d_resp_valid_q;
  logic [LINE_W-1:0]   d_resp_data_q;
  logic                d_resp_err_q;
  logic                busy_q;

  logic                grant_d_s;
  logic [ADDR_W-1:0]   addr_sel_s;
  logic [7:0]          cnt_d;
  logic [LINE_W-1:0]   rdata_s;

  // Arbitration choice, next wait count and read data to capture.
  always_comb begin
    grant_d_s  = d_req_valid & (~i_req_valid | ~last_d_q);
    addr_sel_s = grant_d_s ? d_req_addr : i_req_addr;
    cnt_d      = cnt_q + 8'd1;
    rdata_s    = mem_req_rw_q ? {LINE_W{1'b0}} : mem_data_read;
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      owner_q          <= 1'b0;
      last_d_q         <= 1'b1;
      cnt_q            <= 8'd0;
      mem_req_valid_q  <= 1'b0;
      mem_req_rw_q     <= 1'b0;
      mem_req_addr_q   <= {ADDR_W{1'b0}};
      mem_data_write_q <= {LINE_W{1'b0}};
      i_resp_valid_q   <= 1'b0;
      i_resp_data_q    <= {LINE_W{1'b0}};
      i_resp_err_q     <= 1'b0;
      d_resp_valid_q   <= 1'b0;
      d_resp_data_q    <= {LINE_W{1'b0}};
      d_resp_err_q     <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid || d_req_valid) begin
            owner_q          <= grant_d_s;
            last_d_q         <= grant_d_s;
            mem_req_valid_q  <= 1'b1;
            mem_req_rw_q     <= grant_d_s & d_req_rw;
            mem_req_addr_q   <= addr_sel_s & LINE_MASK;
            mem_data_write_q <= grant_d_s ? d_req_wdata : {LINE_W{1'b0}};
            busy_q           <= 1'b1;
            state_q          <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          // mem_ready has priority over a simultaneous timeout.
          if (mem_ready) begin
            i_resp_valid_q <= ~owner_q;
            d_resp_valid_q <= owner_q;
            i_resp_data_q  <= owner_q ? {LINE_W{1'b0}} : rdata_s;
            d_resp_data_q  <= owner_q ? rdata_s : {LINE_W{1'b0}};
            i_resp_err_q   <= 1'b0;
            d_resp_err_q   <= 1'b0;
            state_q        <= ST_RESP;
          end else if (cnt_d == TIMEOUT_C) begin
            i_resp_valid_q <= ~owner_q;
            d_resp_valid_q <= owner_q;
            i_resp_data_q  <= {LINE_W{1'b0}};
            d_resp_data_q  <= {LINE_W{1'b0}};
            i_resp_err_q   <= ~owner_q;
            d_resp_err_q   <= owner_q;
            state_q        <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: begin
          i_resp_valid_q <= 1'b0;
          d_resp_valid_q <= 1'b0;
          i_resp_data_q  <= {LINE_W{1'b0}};
          d_resp_data_q  <= {LINE_W{1'b0}};
          i_resp_err_q   <= 1'b0;
          d_resp_err_q   <= 1'b0;
          cnt_q          <= 8'd0;
          busy_q         <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_rw     = mem_req_rw_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign mem_data_write = mem_data_write_q;
  assign i_resp_valid   = i_resp_valid_q;
  assign i_resp_data    = i_resp_data_q;
  assign i_resp_err     = i_resp_err_q;
  assign d_resp_valid   = d_resp_valid_q;
  assign d_resp_data    = d_resp_data_q;
  assign d_resp_err     = d_resp_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_line_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_req_valid, d_req_valid, d_req_rw, mem_ready;
  logic [7:0]   i_req_addr, d_req_addr, mem_req_addr;
  logic [127:0] d_req_wdata, mem_data_read, mem_data_write, i_resp_data, d_resp_data;
  logic         i_resp_valid, i_resp_err, d_resp_valid, d_resp_err;
  logic         mem_req_valid, mem_req_rw, busy;

  always #5 clk = ~clk;

  mem_line_arbiter #(.ADDR_W(8), .LINE_W(128), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
    .mem_ready(mem_ready), .busy(busy)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural single-cycle memory with optional extra delay, stall and stray ready.
  logic [127:0] mem_arr [256];
  bit  stall = 1'b0;
  bit  stray_issue = 1'b0;
  int  mem_delay = 0;
  int  stray_idle_req = 0;
  int  stray_idle_ack = 0;
  bit  pend;
  bit  prw;
  logic [7:0] paddr;
  int  wcnt;

  initial begin
    for (int k = 0; k < 256; k++) mem_arr[k] = {4{24'hC0FFEE, 8'(k)}};
    pend = 1'b0;
    mem_ready = 1'b0;
    mem_data_read = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_data_read = '0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (stray_idle_req != stray_idle_ack) begin
          stray_idle_ack = stray_idle_req;
          mem_ready = 1'b1;
          mem_data_read = {4{32'hDEADBEEF}};
        end
        if (pend) begin
          if (wcnt == 0) begin
            mem_ready = 1'b1;
            mem_data_read = prw ? {4{32'h5A5A5A5A}} : mem_arr[paddr];
            pend = 1'b0;
          end else begin
            wcnt--;
          end
        end
        if (mem_req_valid && !stall) begin
          pend  = 1'b1;
          paddr = mem_req_addr;
          prw   = mem_req_rw;
          wcnt  = mem_delay;
          if (mem_req_rw) mem_arr[mem_req_addr] = mem_data_write;
          if (stray_issue) begin
            mem_ready = 1'b1;
            mem_data_read = {4{32'hBAD0BAD0}};
          end
        end
      end
    end
  end

  // One complete directed transaction with latency, handshake and response checks.
  task automatic txn(input string nm, input bit side, input bit rw, input logic [7:0] addr,
                     input logic [127:0] wd, input logic [127:0] exp_data,
                     input bit exp_err, input int exp_lat);
    int t = 0;
    int nreq = 0;
    bit got = 1'b0;
    if (side) begin
      d_req_valid = 1'b1; d_req_rw = rw; d_req_addr = addr; d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    while (!got && t < 60) begin
      step();
      t++;
      if (mem_req_valid) begin
        nreq++;
        chk({nm, " mem_addr"}, mem_req_addr, addr & 8'hFC);
        chk({nm, " mem_rw"}, mem_req_rw, rw);
        if (rw) chk({nm, " mem_wdata"}, mem_data_write, wd);
      end
      if (i_resp_valid || d_resp_valid) begin
        got = 1'b1;
        chk({nm, " resp_side"}, d_resp_valid, side);
        chk({nm, " resp_excl"}, i_resp_valid & d_resp_valid, 0);
        chk({nm, " resp_data"}, side ? d_resp_data : i_resp_data, exp_data);
        chk({nm, " resp_err"}, side ? d_resp_err : i_resp_err, exp_err);
        chk({nm, " other_data"}, side ? i_resp_data : d_resp_data, 0);
        chk({nm, " latency"}, t, exp_lat);
      end
    end
    chk({nm, " responded"}, got, 1);
    chk({nm, " one_mem_req"}, nreq, 1);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    step();
    chk({nm, " pulse_end"}, {i_resp_valid, d_resp_valid, busy}, 0);
    chk({nm, " data_cleared"}, i_resp_data | d_resp_data, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk({nm, " idle_reached"}, busy, 0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit           side;
    bit           rw;
    logic [7:0]   addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  // Random-phase reference model state.
  bit           m_last_d;
  bit           m_own_d;
  int           cd;
  logic [127:0] m_exp;
  logic [7:0]   m_addr;
  bit           m_rw;
  int           ngrant;
  int           tg;
  bit           gside;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h10, {32{4'hA}}, 128'h0};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 128'h0, {32{4'hA}}};
    vecs[2] = '{1'b0, 1'b0, 8'h13, 128'h0, {32{4'hA}}};
    vecs[3] = '{1'b1, 1'b0, 8'h12, {32{4'h7}}, {32{4'hA}}};
    vecs[4] = '{1'b1, 1'b1, 8'h23, {32{4'h5}}, 128'h0};
    vecs[5] = '{1'b0, 1'b0, 8'h20, 128'h0, {32{4'h5}}};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 128'h0, 128'hC0FFEEFC_C0FFEEFC_C0FFEEFC_C0FFEEFC};

    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_rw = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    rst = 1'b1;
    step();
    chk("reset_ctrl", {mem_req_valid, mem_req_rw, busy, i_resp_valid, d_resp_valid, i_resp_err, d_resp_err}, 0);
    chk("reset_addr", mem_req_addr, 0);
    chk("reset_data", i_resp_data | d_resp_data | mem_data_write, 0);
    step();
    rst = 1'b0;

    // Simultaneous requests after reset: I first, then strict alternation every 4 cycles.
    i_req_valid = 1'b1; i_req_addr = 8'h04;
    d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 8'h08;
    ngrant = 0;
    for (int t = 1; t <= 18; t++) begin
      step();
      if (mem_req_valid) begin
        gside = (mem_req_addr == 8'h08);
        chk("tie_grant_side", gside, ngrant % 2);
        chk("tie_grant_time", t, 1 + 4 * ngrant);
        ngrant++;
      end
    end
    chk("tie_grant_count", ngrant, 5);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    wait_idle("tie");

    for (int v = 0; v < 7; v++)
      txn($sformatf("vec%0d", v), vecs[v].side, vecs[v].rw, vecs[v].addr,
          vecs[v].wdata, vecs[v].exp, 1'b0, 3);

    // Stray ready during ISSUE must be ignored; real data arrives in WAIT.
    stray_issue = 1'b1;
    txn("stray_issue", 1'b0, 1'b0, 8'h21, 128'h0, {32{4'h5}}, 1'b0, 3);
    stray_issue = 1'b0;
    stray_idle_req++;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stray_idle_quiet", {i_resp_valid, d_resp_valid, busy, mem_req_valid}, 0);
    end

    mem_delay = 5;
    txn("slow_mem", 1'b1, 1'b0, 8'h22, 128'h0, {32{4'h5}}, 1'b0, 8);
    mem_delay = 0;

    stall = 1'b1;
    txn("timeout", 1'b1, 1'b0, 8'h40, 128'h0, 128'h0, 1'b1, 18);
    stall = 1'b0;
    txn("after_timeout", 1'b0, 1'b0, 8'h41, 128'h0, 128'hC0FFEE40_C0FFEE40_C0FFEE40_C0FFEE40, 1'b0, 3);

    // Reset in WAIT: outputs clear at once and the abandoned request never answers.
    stall = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 8'h30;
    for (int k = 0; k < 5; k++) step();
    chk("rst_mid_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {mem_req_valid, mem_req_rw, busy, i_resp_valid, d_resp_valid, i_resp_err}, 0);
    chk("rst_mid_addr", mem_req_addr, 0);
    i_req_valid = 1'b0;
    step();
    rst = 1'b0;
    stall = 1'b0;
    ngrant = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (i_resp_valid || d_resp_valid || busy) ngrant++;
    end
    chk("rst_mid_no_resp", ngrant, 0);
    txn("after_rst", 1'b0, 1'b0, 8'h31, 128'h0, 128'hC0FFEE30_C0FFEE30_C0FFEE30_C0FFEE30, 1'b0, 3);

    // Randomized traffic against a transaction-level model of arbitration and memory.
    for (int ph = 0; ph < 2; ph++) begin
      mem_delay = ph * 2;
      do_reset();
      m_last_d = 1'b1;
      cd = -1;
      m_own_d = 1'b0;
      for (int c = 0; c < 400; c++) begin
        step();
        if (cd > 0) cd--;
        chk("rnd_i_valid", i_resp_valid, (cd == 0) && !m_own_d);
        chk("rnd_d_valid", d_resp_valid, (cd == 0) && m_own_d);
        if (cd == 0) begin
          chk("rnd_data", m_own_d ? d_resp_data : i_resp_data, m_exp);
          chk("rnd_err", i_resp_err | d_resp_err, 0);
          if (m_own_d) d_req_valid = 1'b0;
          else i_req_valid = 1'b0;
          cd = -1;
        end
        if (mem_req_valid) begin
          chk("rnd_req_pending", i_req_valid | d_req_valid, 1);
          chk("rnd_no_overlap", cd, -1);
          if (i_req_valid && d_req_valid) m_own_d = !m_last_d;
          else m_own_d = d_req_valid;
          m_last_d = m_own_d;
          m_addr = (m_own_d ? d_req_addr : i_req_addr) & 8'hFC;
          m_rw = m_own_d & d_req_rw;
          chk("rnd_mem_addr", mem_req_addr, m_addr);
          chk("rnd_mem_rw", mem_req_rw, m_rw);
          if (m_rw) chk("rnd_mem_wdata", mem_data_write, d_req_wdata);
          m_exp = m_rw ? 128'h0 : mem_arr[m_addr];
          cd = 2 + mem_delay;
        end
        if (!i_req_valid && $urandom_range(0, 3) == 0) begin
          i_req_valid = 1'b1;
          i_req_addr = 8'($urandom_range(0, 255));
        end
        if (!d_req_valid && $urandom_range(0, 3) == 0) begin
          d_req_valid = 1'b1;
          d_req_rw = 1'($urandom_range(0, 1));
          d_req_addr = 8'($urandom_range(0, 255));
          d_req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      wait_idle("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
